// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// decodes datapath strobes from state and ins, counts retirements and halts on illegal encodings.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int MAX_INS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LW  = 7'h03;
  localparam logic [6:0] OPC_SW  = 7'h23;
  localparam logic [6:0] OPC_BEQ = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [6:0]       opc;
  logic             alu_ok;
  logic [2:0]       alu_op;
  logic             retire;
  logic             unused_ins;

  // Returns {supported, ALU op} for a funct3; unsupported encodings make the caller halt.
  function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  return {1'b1, (sub ? OP_SUB : OP_ADD)};
      3'b111:  return {1'b1, OP_AND};
      3'b110:  return {1'b1, OP_OR};
      3'b010:  return {1'b1, OP_SLT};
      default: return {1'b0, OP_ADD};
    endcase
  endfunction

  assign opc              = ins[6:0];
  assign {alu_ok, alu_op} = alu_decode(ins[14:12], (opc == OPC_R) && ins[30]);
  assign unused_ins       = ^{ins[31], ins[29:15], ins[11:7]};

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    retire    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    op        = OP_ADD;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Mem2Reg   = 1'b0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opc)
          OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BEQ, OPC_JAL: state_d = S_EXEC;
          default:                                         state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        case (opc)
          OPC_R, OPC_I: begin
            ALUSrc = (opc == OPC_I);
            if (alu_ok) begin
              op      = alu_op;
              state_d = S_WB;
            end else begin
              state_d = S_HALT;
            end
          end
          OPC_LW, OPC_SW: begin
            ALUSrc  = 1'b1;
            state_d = S_MEM;
          end
          OPC_BEQ: begin
            op      = OP_SUB;
            PCWrite = 1'b1;
            PCSrc   = zero ? 2'b01 : 2'b00;
            retire  = 1'b1;
          end
          OPC_JAL: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            PCSrc    = 2'b10;
            retire   = 1'b1;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        case (opc)
          OPC_LW: begin
            MemRead = 1'b1;
            ALUSrc  = 1'b1;
            state_d = S_WB;
          end
          OPC_SW: begin
            MemWrite = 1'b1;
            PCWrite  = 1'b1;
            retire   = 1'b1;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        retire   = 1'b1;
        if (opc == OPC_LW) begin
          Mem2Reg = 1'b1;
        end else begin
          ALUSrc = (opc == OPC_I);
          op     = alu_op;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // A retiring edge either returns to FETCH or stops once the retirement budget is used up.
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
      state_d   = ((MAX_INS != 0) && (instret_d == CNT_W'(MAX_INS))) ? S_HALT : S_FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written corner sequences,
// and randomized instructions checked against a per-instruction-class reference model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, zero;
  logic [31:0] ins;

  logic        IRWrite, PCWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, halted;
  logic [1:0]  PCSrc;
  logic [2:0]  op, state;
  logic [31:0] instret;

  logic        l_irw, l_pcw, l_rw, l_as, l_mr, l_mw, l_m2r, l_halted;
  logic [1:0]  l_pcs;
  logic [2:0]  l_op, l_state;
  logic [31:0] l_instret;

  logic        w_irw, w_pcw, w_rw, w_as, w_mr, w_mw, w_m2r, w_halted;
  logic [1:0]  w_pcs;
  logic [2:0]  w_op, w_state;
  logic [1:0]  w_instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32), .MAX_INS(0)) dut (
    .clk(clk), .reset(reset), .run(run), .ins(ins), .zero(zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .op(op), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem2Reg(Mem2Reg), .state(state), .halted(halted), .instret(instret)
  );

  multicycle_ctrl #(.CNT_W(32), .MAX_INS(3)) dut_lim (
    .clk(clk), .reset(reset), .run(run), .ins(ins), .zero(zero),
    .IRWrite(l_irw), .PCWrite(l_pcw), .PCSrc(l_pcs), .RegWrite(l_rw),
    .ALUSrc(l_as), .op(l_op), .MemRead(l_mr), .MemWrite(l_mw),
    .Mem2Reg(l_m2r), .state(l_state), .halted(l_halted), .instret(l_instret)
  );

  multicycle_ctrl #(.CNT_W(2), .MAX_INS(0)) dut_wrap (
    .clk(clk), .reset(reset), .run(run), .ins(ins), .zero(zero),
    .IRWrite(w_irw), .PCWrite(w_pcw), .PCSrc(w_pcs), .RegWrite(w_rw),
    .ALUSrc(w_as), .op(w_op), .MemRead(w_mr), .MemWrite(w_mw),
    .Mem2Reg(w_m2r), .state(w_state), .halted(w_halted), .instret(w_instret)
  );

  typedef struct packed {
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic       as;
    logic [2:0] op;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic [2:0] st;
    logic       hl;
  } outs_t;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          lat;
    logic [2:0]  eop;
    logic        eas;
    logic [1:0]  epcs;
    logic        epcw;
    logic        rw_any;
    logic        mr_any;
    logic        mw_any;
    logic        m2r_any;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    model_cnt = 0;
  outs_t exp_q[$];
  bit    m_ret, m_halt;
  vec_t  tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic outs_t pk();
    outs_t o;
    o.irw = IRWrite;  o.pcw = PCWrite;  o.pcs = PCSrc;   o.rw = RegWrite;
    o.as  = ALUSrc;   o.op  = op;       o.mr  = MemRead; o.mw = MemWrite;
    o.m2r = Mem2Reg;  o.st  = state;    o.hl  = halted;
    return o;
  endfunction

  function automatic outs_t base(input int st);
    outs_t o;
    o    = '0;
    o.op = 3'b010;
    o.st = st[2:0];
    o.hl = (st == 7);
    return o;
  endfunction

  function automatic bit legal(input logic [6:0] opc);
    return opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
  endfunction

  // Reference: the expected output vector of every cycle from FETCH to retirement.
  function automatic void build(input logic [31:0] in, input logic z);
    outs_t      o;
    bit         ok, isi;
    logic [2:0] aop;
    exp_q.delete();
    m_ret  = 0;
    m_halt = 0;
    isi    = (in[6:0] == 7'h13);
    o = base(1); o.irw = 1'b1; exp_q.push_back(o);
    exp_q.push_back(base(2));
    case (in[6:0])
      7'h33, 7'h13: begin
        ok = 1;
        case (in[14:12])
          3'd0:    aop = (!isi && in[30]) ? 3'b110 : 3'b010;
          3'd7:    aop = 3'b000;
          3'd6:    aop = 3'b001;
          3'd2:    aop = 3'b111;
          default: begin ok = 0; aop = 3'b010; end
        endcase
        o = base(3); o.as = isi; o.op = aop; exp_q.push_back(o);
        if (!ok) m_halt = 1;
        else begin
          o = base(5); o.as = isi; o.op = aop; o.rw = 1'b1; o.pcw = 1'b1;
          exp_q.push_back(o);
          m_ret = 1;
        end
      end
      7'h03: begin
        o = base(3); o.as = 1'b1; exp_q.push_back(o);
        o = base(4); o.as = 1'b1; o.mr = 1'b1; exp_q.push_back(o);
        o = base(5); o.rw = 1'b1; o.pcw = 1'b1; o.m2r = 1'b1; exp_q.push_back(o);
        m_ret = 1;
      end
      7'h23: begin
        o = base(3); o.as = 1'b1; exp_q.push_back(o);
        o = base(4); o.mw = 1'b1; o.pcw = 1'b1; exp_q.push_back(o);
        m_ret = 1;
      end
      7'h63: begin
        o = base(3); o.op = 3'b110; o.pcw = 1'b1; o.pcs = z ? 2'b01 : 2'b00;
        exp_q.push_back(o);
        m_ret = 1;
      end
      7'h6F: begin
        o = base(3); o.rw = 1'b1; o.pcw = 1'b1; o.pcs = 2'b10; exp_q.push_back(o);
        m_ret = 1;
      end
      default: m_halt = 1;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    ins   = 32'h0;
    zero  = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_outs", 64'(pk()), 64'(base(0)));
    chk("rst_instret", 64'(instret), 64'd0);
    reset     = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    chk("idle_hold", 64'(state), 64'd0);
    run = 1'b1;
    @(negedge clk);
    chk("idle_to_fetch", 64'(state), 64'd1);
  endtask

  task automatic run_model(input logic [31:0] in, input logic z);
    build(in, z);
    ins  = in;
    zero = z;
    foreach (exp_q[i]) begin
      #1;
      chk($sformatf("rand_cyc%0d_ins%08h", i, in), 64'(pk()), 64'(exp_q[i]));
      run = 1'($urandom);
      @(negedge clk);
    end
    if (m_ret) model_cnt++;
    chk("rand_instret", 64'(instret), 64'(model_cnt));
    if (m_halt) begin
      repeat (2) begin
        #1;
        chk("rand_halt", 64'(pk()), 64'(base(7)));
        run = 1'($urandom);
        @(negedge clk);
      end
      do_reset();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc, retired;
    logic [2:0]  c_op;
    logic [1:0]  c_pcs;
    logic        c_as, c_pcw, f_rw, f_mr, f_mw, f_m2r;
    logic [31:0] r;
    logic [6:0]  opc;

    tbl[0] = '{32'h40B50533, 1'b0, 4, 3'b110, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h00452283, 1'b0, 5, 3'b010, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h00552423, 1'b0, 4, 3'b010, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h00B50463, 1'b1, 3, 3'b110, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h00B50463, 1'b0, 3, 3'b110, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h0080006F, 1'b0, 3, 3'b010, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h00150513, 1'b0, 4, 3'b010, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h00B56533, 1'b0, 4, 3'b001, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{32'h00A52513, 1'b0, 4, 3'b111, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{32'h00B57533, 1'b0, 4, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    run   = 1'b0;
    ins   = 32'h0;
    zero  = 1'b0;
    do_reset();

    // Directed vectors: latency, EXEC strobes and per-instruction strobe summaries.
    retired = 0;
    foreach (tbl[k]) begin
      ins  = tbl[k].ins;
      zero = tbl[k].z;
      cyc  = 0;
      c_op = 3'bx; c_as = 1'bx; c_pcs = 2'bx; c_pcw = 1'bx;
      f_rw = 0; f_mr = 0; f_mw = 0; f_m2r = 0;
      do begin
        #1;
        cyc++;
        if (state == 3'd3) begin
          c_op = op; c_as = ALUSrc; c_pcs = PCSrc; c_pcw = PCWrite;
        end
        f_rw |= RegWrite; f_mr |= MemRead; f_mw |= MemWrite; f_m2r |= Mem2Reg;
        @(negedge clk);
      end while (state != 3'd1 && cyc < 10);
      retired++;
      chk($sformatf("vec%0d_lat", k), 64'(cyc), 64'(tbl[k].lat));
      chk($sformatf("vec%0d_op", k), 64'(c_op), 64'(tbl[k].eop));
      chk($sformatf("vec%0d_alusrc", k), 64'(c_as), 64'(tbl[k].eas));
      chk($sformatf("vec%0d_pcsrc", k), 64'(c_pcs), 64'(tbl[k].epcs));
      chk($sformatf("vec%0d_exec_pcw", k), 64'(c_pcw), 64'(tbl[k].epcw));
      chk($sformatf("vec%0d_flags", k), 64'({f_rw, f_mr, f_mw, f_m2r}),
          64'({tbl[k].rw_any, tbl[k].mr_any, tbl[k].mw_any, tbl[k].m2r_any}));
      chk($sformatf("vec%0d_instret", k), 64'(instret), 64'(retired));
    end

    // Asynchronous reset arriving during an R-type write-back.
    ins = 32'h40B50533;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (state != 3'd5 && cyc < 8);
    chk("wb_reached", 64'(state), 64'd5);
    #1;
    chk("wb_regwrite", 64'(RegWrite), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_state", 64'(state), 64'd0);
    chk("async_strobes", 64'({RegWrite, PCWrite}), 64'd0);
    chk("async_instret", 64'(instret), 64'd0);
    do_reset();

    // Illegal opcode: sticky HALT regardless of run.
    ins = 32'h0000007F;
    @(negedge clk);
    #1;
    chk("ill_decode", 64'(state), 64'd2);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("ill_halt_outs", 64'(pk()), 64'(base(7)));
      chk("ill_instret", 64'(instret), 64'd0);
      run = ~run;
      @(negedge clk);
    end
    do_reset();

    // Retirement limit (MAX_INS=3) and counter wrap (CNT_W=2) on parallel instances.
    for (int k = 1; k <= 5; k++) begin
      ins = 32'h00150513;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (state != 3'd1 && cyc < 10);
      chk("addi_lat", 64'(cyc), 64'd4);
      if (k == 2) chk("lim_before", 64'(l_state), 64'd1);
      if (k >= 3) begin
        chk("lim_halt", 64'({l_state, l_halted}), 64'({3'd7, 1'b1}));
        chk("lim_instret", 64'(l_instret), 64'd3);
      end
      if (k == 4) chk("wrap_zero", 64'(w_instret), 64'd0);
      if (k == 5) chk("wrap_one", 64'(w_instret), 64'd1);
    end
    do_reset();

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      case ($urandom_range(0, 6))
        0: r[6:0] = 7'h33;
        1: r[6:0] = 7'h13;
        2: r[6:0] = 7'h03;
        3: r[6:0] = 7'h23;
        4: r[6:0] = 7'h63;
        5: r[6:0] = 7'h6F;
        default: begin
          do opc = 7'($urandom); while (legal(opc));
          r[6:0] = opc;
        end
      endcase
      run_model(r, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the yIF/yID/yEX datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. In each state it drives the datapath strobes: PC/IR write, RegWrite, ALUSrc, ALU op, memory read/write, Mem2Reg and PC source. It counts retired instructions and halts on an illegal opcode.

Parameters:
CNT_W, 32, width of the retired-instruction counter
MAX_INS, 0, stop after this many retirements; 0 means unlimited

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  level; leave IDLE and start fetching while high
ins  in  32  instruction from the datapath; stable from DECODE until the instruction retires
zero  in  1  ALU zero flag from yEX, sampled in EXEC
IRWrite  out  1  latch the instruction register
PCWrite  out  1  update the PC this cycle
PCSrc  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jTarget
RegWrite  out  1  register file write enable
ALUSrc  out  1  0 = rd2, 1 = imm
op  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
MemRead  out  1  data memory read
MemWrite  out  1  data memory write
Mem2Reg  out  1  write-back source: 0 = ALU z, 1 = memory
state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7
halted  out  1  high in HALT
instret  out  CNT_W  count of retired instructions

Behaviour:
- reset asserted, asynchronous: state=IDLE, instret=0. Every strobe output is 0. op=010 and PCSrc=00.
- Outputs are a combinational decode of state and ins. Registers are state and instret only.
- Default in every state: all strobes 0, op=010, ALUSrc=0, PCSrc=00.
- IDLE: stays here while run=0. run=1 -> FETCH.
- FETCH: IRWrite=1 -> DECODE.
- DECODE: operand read only, no strobes. Branch on ins[6:0]:
  - 0x33 (R), 0x13 (I-ALU), 0x03 (LW), 0x23 (SW), 0x63 (BEQ), 0x6F (JAL) -> EXEC.
  - any other opcode -> HALT.
- EXEC:
  - R: ALUSrc=0. op comes from funct3: 000 gives ADD, or SUB when ins[30]=1; 111 AND; 110 OR; 010 SLT. Any other funct3 -> HALT with no writes. Otherwise -> WB.
  - I-ALU: ALUSrc=1. Same funct3 map, ins[30] ignored (ADD only). -> WB.
  - LW / SW: ALUSrc=1, op=ADD -> MEM.
  - BEQ: ALUSrc=0, op=SUB, PCWrite=1. PCSrc=01 if zero=1, else 00. Retire -> FETCH.
  - JAL: RegWrite=1 (link), PCWrite=1, PCSrc=10. Retire -> FETCH.
- MEM:
  - LW: MemRead=1, ALUSrc=1, op=ADD held -> WB.
  - SW: MemWrite=1, PCWrite=1, PCSrc=00. Retire -> FETCH.
- WB: RegWrite=1, PCWrite=1, PCSrc=00.
  - LW: Mem2Reg=1.
  - R/I: Mem2Reg=0, with ALUSrc/op held from EXEC.
  - Retire -> FETCH.
- Latency in cycles, FETCH to retirement: R/I 4, LW 5, SW 4, BEQ 3, JAL 3.
- Retire: instret increments by 1 on the exiting edge and wraps at 2^CNT_W without flagging.
- MAX_INS: if nonzero and instret reaches MAX_INS on a retire edge, next state is HALT instead of FETCH.
- run is sampled only in IDLE. Deasserting run mid-instruction has no effect.
- HALT is sticky: only reset leaves it. In HALT all strobes are 0 and halted=1.
- Reset mid-instruction: return to IDLE immediately, even mid-MEM/WB. No partial write strobe survives the reset edge.

Test Plan:
- Reset: reset=1 during an R-type WB -> state=0, RegWrite=0, PCWrite=0 with no clock edge; instret=0.
- R-type: run=1, ins=0x40B50533 (sub) -> states 1,2,3,5. EXEC op=110 ALUSrc=0. WB RegWrite=1 PCWrite=1 Mem2Reg=0. instret=1 after 4 cycles.
- Load/store: ins=0x00452283 (lw) -> 5 cycles; MEM MemRead=1; WB Mem2Reg=1 RegWrite=1. Next ins=0x00552423 (sw) -> MEM MemWrite=1 PCWrite=1, RegWrite never 1.
- Branch and jump:
  - ins=0x00B50463 (beq), zero=1 -> EXEC PCWrite=1 PCSrc=01, 3 cycles.
  - Same instruction with zero=0 -> PCSrc=00.
  - ins=0x0080006F (jal) -> EXEC RegWrite=1 PCSrc=10.
- Illegal opcode: ins=0x0000007F -> DECODE goes to HALT; halted=1, no strobes for 10 cycles, instret unchanged. run toggling does not leave HALT.
- Limit and wrap: MAX_INS=3 with three addi -> HALT after the third retire, instret=3. Separately, CNT_W=2 with 5 addi and MAX_INS=0 -> instret=1 after the fifth.
